// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns, one 32-bit column per clock.
// Ports: clk, rst (async high), in_valid/in_ready/in_state/in_last, out_valid/out_ready/out_state, busy.
module mix_columns_seq #(
  parameter bit INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } st_t;

  st_t          st;
  st_t          st_nxt;
  logic [1:0]   col_cnt;
  logic [127:0] blk;
  logic         last;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] col_mix(input logic [31:0] w);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] o  [4];
    logic [1:0] k;
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a[i]  = w[8*i +: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      k = 2'(r);
      if (!INV) begin
        // 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3]
        o[r] = m2[k] ^ m2[k+2'd1] ^ a[k+2'd1]
             ^ a[k+2'd2] ^ a[k+2'd3];
      end else begin
        // e*a[r] ^ b*a[r+1] ^ d*a[r+2] ^ 9*a[r+3]
        o[r] = (m8[k] ^ m4[k] ^ m2[k])
             ^ (m8[k+2'd1] ^ m2[k+2'd1] ^ a[k+2'd1])
             ^ (m8[k+2'd2] ^ m4[k+2'd2] ^ a[k+2'd2])
             ^ (m8[k+2'd3] ^ a[k+2'd3]);
      end
    end
    res = {o[3], o[2], o[1], o[0]};
    return res;
  endfunction

  always_comb begin
    col_in  = blk[{col_cnt, 5'd0} +: 32];
    col_out = last ? col_in : col_mix(col_in);
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (in_valid) st_nxt = BUSY;
      BUSY:    if (col_cnt == 2'd3) st_nxt = DONE;
      DONE:    if (out_ready) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  assign in_ready  = (st == IDLE);
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      col_cnt   <= 2'd0;
      blk       <= '0;
      last      <= 1'b0;
      out_state <= '0;
    end else begin
      st <= st_nxt;
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            blk     <= in_state;
            last    <= in_last;
            col_cnt <= 2'd0;
          end
        end
        BUSY: begin
          out_state[{col_cnt, 5'd0} +: 32] <= col_out;
          // hold at 3 so the counter never wraps inside a block
          if (col_cnt != 2'd3) col_cnt <= col_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: forward and inverse instances
// driven in lockstep, checked against a GF(2^8) matrix reference model.
module tb_mix_columns_seq;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic [127:0] in_state = '0;
  logic         in_last = 0;
  logic         out_ready;
  logic         ir0, ir1, ov0, ov1, bz0, bz1;
  logic [127:0] os0, os1;

  bit rand_rdy = 0;
  bit rdy_force = 1;
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  logic [127:0] q0[$], q1[$];
  int           a0[$], a1[$];
  logic         pv[2], phs[2];
  logic [127:0] ps[2];

  mix_columns_seq #(.INV(1'b0)) u_fwd (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir0),
    .in_state(in_state), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready),
    .out_state(os0), .busy(bz0)
  );

  mix_columns_seq #(.INV(1'b1)) u_inv (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir1),
    .in_state(in_state), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready),
    .out_state(os1), .busy(bz1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(
    logic [127:0] s, bit last, bit inv);
    logic [7:0] cf[4];
    logic [127:0] r = '0;
    logic [7:0] v;
    if (last) return s;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        v = 0;
        for (int k = 0; k < 4; k++)
          v ^= gmul(cf[(k - row + 4) % 4], s[32*c + 8*k +: 8]);
        r[32*c + 8*row +: 8] = v;
      end
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic mon(int d, logic v, logic ir, logic [127:0] s);
    logic [127:0] e;
    int a;
    if (v) chk($sformatf("dut%0d_in_ready_low", d), 128'(ir), 0);
    if (v && !pv[d]) begin
      if ((d == 0 ? a0.size() : a1.size()) == 0) begin
        chk($sformatf("dut%0d_unexpected_out", d), 1, 0);
      end else begin
        a = (d == 0) ? a0.pop_front() : a1.pop_front();
        // accept cycle + 4 BUSY cycles -> DONE in the 5th cycle
        chk($sformatf("dut%0d_latency", d), 128'(cyc - a), 4);
      end
    end
    if (v && pv[d] && !phs[d])
      chk($sformatf("dut%0d_hold_stable", d), s, ps[d]);
    if (v && out_ready) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        chk($sformatf("dut%0d_extra_out", d), 1, 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d_data", d), s, e);
      end
    end
    pv[d]  = v;
    ps[d]  = s;
    phs[d] = v && out_ready;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv  = '{0, 0};
      phs = '{0, 0};
    end else begin
      mon(0, ov0, ir0, os0);
      mon(1, ov1, ir1, os1);
    end
  end

  task automatic send(logic [127:0] s, bit last,
                      logic [127:0] e0, logic [127:0] e1);
    int n = 0;
    while (!ir0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("send_in_ready", 128'(ir0), 1);
    in_state = s;
    in_last  = last;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    // scramble inputs to show the latched copy is used
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_last  = ~last;
    q0.push_back(e0);
    q1.push_back(e1);
    a0.push_back(cyc);
    a1.push_back(cyc);
  endtask

  task automatic rnd_send();
    logic [127:0] s;
    bit l;
    s = {$urandom, $urandom, $urandom, $urandom};
    l = ($urandom_range(0, 3) == 0);
    send(s, l, ref_mix(s, l, 0), ref_mix(s, l, 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", 128'(q0.size() + q1.size()), 0);
  endtask

  logic [127:0] v1, v2, v3, v4;

  initial begin
    v1 = {96'h0, 32'h455313DB};
    v2 = {32'hD5D4D4D4, 32'h01010101, 32'hC6C6C6C6, 32'h5C220AF2};
    v3 = {64'h0, 32'hF8BD7E4D, 32'hBCA14D8E};
    v4 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(ov0), 0);
    chk("rst_out_state", os0, 0);
    chk("rst_in_ready", 128'(ir0), 1);
    chk("rst_busy", 128'(bz0), 0);
    rst = 0;
    @(posedge clk); #1;

    send(v1, 0, {96'h0, 32'hBCA14D8E}, ref_mix(v1, 0, 1));
    send(v2, 0,
         {32'hD6D7D5D5, 32'h01010101, 32'hC6C6C6C6, 32'h9D58DC9F},
         ref_mix(v2, 0, 1));
    send(v3, 0, ref_mix(v3, 0, 0),
         {64'h0, 32'h4C31262D, 32'h455313DB});
    send(v4, 1, v4, v4);
    drain();

    // backpressure with an ignored second request
    rdy_force = 0;
    rnd_send();
    begin
      int n = 0;
      while (!ov0 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("bp_reach_done", 128'(ov0), 1);
    end
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 0;
    chk("bp_still_valid", 128'(ov0), 1);
    chk("bp_busy", 128'(bz0), 1);
    rdy_force = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_back_idle", 128'(ir0), 1);
    rnd_send();
    drain();

    // abort mid-block at col_cnt == 2
    rnd_send();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("abort_out_valid", 128'(ov0), 0);
    chk("abort_out_state", os0, 0);
    chk("abort_in_ready", 128'(ir0), 1);
    chk("abort_busy", 128'(bz1), 0);
    q0.delete(); q1.delete(); a0.delete(); a1.delete();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rnd_send();
    drain();

    rand_rdy = 1;
    for (int i = 0; i < 30; i++) rnd_send();
    drain();
    rand_rdy = 0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
